// File: rtl/decode_pkg.sv
// Shared decode types: RV64I opcodes, functional-unit classes and the decode packet.
package decode_pkg;

    localparam int PC_W  = 64;
    localparam int IMM_W = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_BRU = 3'd1,
        FU_LDU = 3'd2,
        FU_STU = 3'd3,
        FU_CSR = 3'd4
    } fu_type_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [31:0]      inst;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rd_wen;
        logic [IMM_W-1:0] imm;
        fu_type_e         fu_type;
        logic             illegal;
    } dec_pkt_t;

    // Reassembles the scattered immediate bits and sign-extends from inst[31].
    function automatic logic [IMM_W-1:0] build_imm(input logic [31:0] inst, input imm_type_e t);
        case (t)
            IMM_I:   return {{(IMM_W-12){inst[31]}}, inst[31:20]};
            IMM_S:   return {{(IMM_W-12){inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   return {{(IMM_W-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   return {{(IMM_W-32){inst[31]}}, inst[31:12], 12'b0};
            IMM_J:   return {{(IMM_W-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/rv64_decoder.sv
// Combinational RV64I field decoder: raw instruction + PC in, decode packet out.
module rv64_decoder
    import decode_pkg::*;
(
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] pc,
    output dec_pkt_t        pkt
);

    imm_type_e imm_type;
    fu_type_e  fu;
    logic      legal;
    logic      writes_rd;

    always_comb begin
        imm_type  = IMM_NONE;
        fu        = FU_ALU;
        legal     = 1'b1;
        writes_rd = 1'b1;
        case (inst[6:0])
            OPC_OP, OPC_OP_32:         imm_type = IMM_NONE;
            OPC_OP_IMM, OPC_OP_IMM_32: imm_type = IMM_I;
            OPC_LUI, OPC_AUIPC:        imm_type = IMM_U;
            OPC_BRANCH:   begin fu = FU_BRU; imm_type = IMM_B; writes_rd = 1'b0; end
            OPC_JAL:      begin fu = FU_BRU; imm_type = IMM_J; end
            OPC_JALR:     begin fu = FU_BRU; imm_type = IMM_I; end
            OPC_LOAD:     begin fu = FU_LDU; imm_type = IMM_I; end
            OPC_STORE:    begin fu = FU_STU; imm_type = IMM_S; writes_rd = 1'b0; end
            OPC_SYSTEM:   begin fu = FU_CSR; imm_type = IMM_I; end
            OPC_MISC_MEM: begin fu = FU_CSR; imm_type = IMM_I; writes_rd = 1'b0; end
            default:      legal = 1'b0;
        endcase
        if (inst[1:0] != 2'b11) legal = 1'b0;
        // Illegal encodings leave a neutral ALU packet with no side effects.
        if (!legal) begin
            fu        = FU_ALU;
            imm_type  = IMM_NONE;
            writes_rd = 1'b0;
        end

        pkt         = '0;
        pkt.pc      = pc;
        pkt.inst    = inst;
        pkt.rs1     = inst[19:15];
        pkt.rs2     = inst[24:20];
        pkt.rd      = inst[11:7];
        pkt.rd_wen  = writes_rd && (inst[11:7] != 5'd0);
        pkt.imm     = build_imm(inst, imm_type);
        pkt.fu_type = fu;
        pkt.illegal = !legal;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: pops the instruction buffer, decodes into a registered packet,
// and uses a one-entry skid so fifo_read_en never sees backend_stall combinationally.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int PERF_CNT_W = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  redirect_valid,
    input  logic                  ibuffer_instr_valid,
    input  logic [31:0]           ibuffer_inst_out,
    input  logic [PC_W-1:0]       ibuffer_pc_out,
    output logic                  fifo_read_en,
    input  logic                  backend_stall,
    output logic                  dec_valid,
    output logic [PC_W-1:0]       dec_pc,
    output logic [31:0]           dec_inst,
    output logic [4:0]            dec_rs1,
    output logic [4:0]            dec_rs2,
    output logic [4:0]            dec_rd,
    output logic                  dec_rd_wen,
    output logic [XLEN-1:0]       dec_imm,
    output fu_type_e              dec_fu_type,
    output logic                  dec_illegal,
    output logic [PERF_CNT_W-1:0] perf_dispatched
);

    logic                  skid_valid_q, skid_valid_d;
    logic [31:0]           skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]       skid_pc_q, skid_pc_d;
    logic                  dec_valid_q, dec_valid_d;
    dec_pkt_t              pkt_q, pkt_d, pkt_dec;
    logic [PERF_CNT_W-1:0] perf_q, perf_d;

    logic                  xfer;
    logic                  out_free;
    logic [31:0]           src_inst;
    logic [PC_W-1:0]       src_pc;

    assign fifo_read_en = reset_n && !skid_valid_q && !redirect_valid;
    assign xfer         = fifo_read_en && ibuffer_instr_valid;
    assign out_free     = !dec_valid_q || !backend_stall;

    // Skid content is older than the ibuffer head, so it always wins the mux.
    assign src_inst = skid_valid_q ? skid_inst_q : ibuffer_inst_out;
    assign src_pc   = skid_valid_q ? skid_pc_q   : ibuffer_pc_out;

    rv64_decoder u_decoder (
        .inst (src_inst),
        .pc   (src_pc),
        .pkt  (pkt_dec)
    );

    always_comb begin
        dec_valid_d  = dec_valid_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        pkt_d        = pkt_q;
        perf_d       = perf_q;
        if (dec_valid_q && !backend_stall && !redirect_valid) perf_d = perf_q + PERF_CNT_W'(1);

        if (redirect_valid) begin
            dec_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            dec_valid_d  = skid_valid_q || xfer;
            skid_valid_d = 1'b0;
            if (skid_valid_q || xfer) pkt_d = pkt_dec;
        end else if (xfer) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = ibuffer_inst_out;
            skid_pc_d    = ibuffer_pc_out;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dec_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            pkt_q        <= '0;
            perf_q       <= '0;
        end else begin
            dec_valid_q  <= dec_valid_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            pkt_q        <= pkt_d;
            perf_q       <= perf_d;
        end
    end

    assign dec_valid       = dec_valid_q;
    assign dec_pc          = pkt_q.pc;
    assign dec_inst        = pkt_q.inst;
    assign dec_rs1         = pkt_q.rs1;
    assign dec_rs2         = pkt_q.rs2;
    assign dec_rd          = pkt_q.rd;
    assign dec_rd_wen      = pkt_q.rd_wen;
    assign dec_imm         = pkt_q.imm[XLEN-1:0];
    assign dec_fu_type     = pkt_q.fu_type;
    assign dec_illegal     = pkt_q.illegal;
    assign perf_dispatched = perf_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, directed skid/redirect/reset sequences,
// and random traffic against a queue-based reference model.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic        ibuffer_instr_valid;
    logic [31:0] ibuffer_inst_out;
    logic [63:0] ibuffer_pc_out;
    logic        fifo_read_en;
    logic        backend_stall;
    logic        dec_valid;
    logic [63:0] dec_pc;
    logic [31:0] dec_inst;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rd_wen;
    logic [63:0] dec_imm;
    logic [2:0]  dec_fu_type;
    logic        dec_illegal;
    logic [63:0] perf_dispatched;

    int n_chk = 0;
    int n_err = 0;

    decode_stage #(.XLEN(64), .PERF_CNT_W(64)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .redirect_valid      (redirect_valid),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .ibuffer_inst_out    (ibuffer_inst_out),
        .ibuffer_pc_out      (ibuffer_pc_out),
        .fifo_read_en        (fifo_read_en),
        .backend_stall       (backend_stall),
        .dec_valid           (dec_valid),
        .dec_pc              (dec_pc),
        .dec_inst            (dec_inst),
        .dec_rs1             (dec_rs1),
        .dec_rs2             (dec_rs2),
        .dec_rd              (dec_rd),
        .dec_rd_wen          (dec_rd_wen),
        .dec_imm             (dec_imm),
        .dec_fu_type         (dec_fu_type),
        .dec_illegal         (dec_illegal),
        .perf_dispatched     (perf_dispatched)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]  fu;
        logic        wen;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    // Reference decode using signed arithmetic on the whole word.
    function automatic exp_t ref_dec(input logic [31:0] i);
        exp_t   e;
        longint si, imm_i, imm_s, imm_b, imm_u, imm_j;
        si    = longint'($signed(i));
        imm_i = si >>> 20;
        imm_s = ((si >>> 25) <<< 5) | longint'(i[11:7]);
        imm_b = ((si >>> 31) <<< 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
        imm_u = (si >>> 12) <<< 12;
        imm_j = ((si >>> 31) <<< 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
        e.ill = 1'b0;
        e.fu  = 3'd0;
        e.wen = (i[11:7] != 5'd0);
        e.imm = 64'd0;
        case (i[6:0])
            7'h33, 7'h3B: e.imm = 64'd0;
            7'h13, 7'h1B: e.imm = imm_i;
            7'h37, 7'h17: e.imm = imm_u;
            7'h63: begin e.fu = 3'd1; e.imm = imm_b; e.wen = 1'b0; end
            7'h6F: begin e.fu = 3'd1; e.imm = imm_j; end
            7'h67: begin e.fu = 3'd1; e.imm = imm_i; end
            7'h03: begin e.fu = 3'd2; e.imm = imm_i; end
            7'h23: begin e.fu = 3'd3; e.imm = imm_s; e.wen = 1'b0; end
            7'h73: begin e.fu = 3'd4; e.imm = imm_i; end
            7'h0F: begin e.fu = 3'd4; e.imm = imm_i; e.wen = 1'b0; end
            default: begin e.ill = 1'b1; e.wen = 1'b0; end
        endcase
        return e;
    endfunction

    // Reference model: ordered queue of accepted-but-unconsumed instructions.
    // Head is the visible output packet; a second entry means the skid is occupied.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] m_perf;

    always @(posedge clock or negedge reset_n) begin
        bit take;
        if (!reset_n) begin
            mq.delete();
            m_perf = 64'd0;
        end else begin
            take = (mq.size() < 2) && !redirect_valid && ibuffer_instr_valid;
            if (redirect_valid) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && !backend_stall) begin
                    void'(mq.pop_front());
                    m_perf = m_perf + 64'd1;
                end
                if (take) mq.push_back('{pc: ibuffer_pc_out, inst: ibuffer_inst_out});
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            chk("sb_dec_valid", dec_valid, mq.size() > 0);
            chk("sb_fifo_read_en", fifo_read_en, (mq.size() < 2) && !redirect_valid);
            chk("sb_perf", perf_dispatched, m_perf);
            if (mq.size() > 0) begin
                e = ref_dec(mq[0].inst);
                chk("sb_pc", dec_pc, mq[0].pc);
                chk("sb_inst", dec_inst, mq[0].inst);
                chk("sb_regs", {dec_rs1, dec_rs2, dec_rd}, {mq[0].inst[19:15], mq[0].inst[24:20], mq[0].inst[11:7]});
                chk("sb_fu_wen_ill", {dec_fu_type, dec_rd_wen, dec_illegal}, {e.fu, e.wen, e.ill});
                chk("sb_imm", dec_imm, e.imm);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fu;
        logic        wen;
        logic [63:0] imm;
        logic        ill;
    } vec_t;
    vec_t vec[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned got[$];
        logic [63:0]     perf0;
        logic [31:0]     r;
        logic [6:0]      ops[16];
        int              idx, cyc, falls;
        bit              pop, prev_re;

        vec[0]  = '{32'h00500093, 3'd0, 1'b1, 64'd5, 1'b0};                  // addi x1,x0,5
        vec[1]  = '{32'hFE000EE3, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};   // beq x0,x0,-4
        vec[2]  = '{32'h00000000, 3'd0, 1'b0, 64'd0, 1'b1};                  // all zero
        vec[3]  = '{32'h123452B7, 3'd0, 1'b1, 64'h0000000012345000, 1'b0};   // lui x5
        vec[4]  = '{32'hFF812183, 3'd2, 1'b1, 64'hFFFFFFFFFFFFFFF8, 1'b0};   // lw x3,-8(x2)
        vec[5]  = '{32'h00312623, 3'd3, 1'b0, 64'd12, 1'b0};                 // sw x3,12(x2)
        vec[6]  = '{32'h001000EF, 3'd1, 1'b1, 64'h800, 1'b0};                // jal x1,2048
        vec[7]  = '{32'h00000073, 3'd4, 1'b0, 64'd0, 1'b0};                  // ecall
        vec[8]  = '{32'h0FF0000F, 3'd4, 1'b0, 64'hFF, 1'b0};                 // fence
        vec[9]  = '{32'h002081B3, 3'd0, 1'b1, 64'd0, 1'b0};                  // add x3,x1,x2
        vec[10] = '{32'h00000001, 3'd0, 1'b0, 64'd0, 1'b1};                  // compressed
        vec[11] = '{32'h0000007F, 3'd0, 1'b0, 64'd0, 1'b1};                  // unknown opcode
        vec[12] = '{32'hFFFFF017, 3'd0, 1'b0, 64'hFFFFFFFFFFFFF000, 1'b0};   // auipc x0

        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37,
                7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h00, 7'h7F, 7'h2B};

        reset_n             = 1'b1;
        redirect_valid      = 1'b0;
        ibuffer_instr_valid = 1'b0;
        ibuffer_inst_out    = '0;
        ibuffer_pc_out      = '0;
        backend_stall       = 1'b0;
        #1 reset_n = 1'b0;
        ibuffer_instr_valid = 1'b1;
        tick();
        tick();
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_fifo_read_en", fifo_read_en, 0);
        chk("rst_perf", perf_dispatched, 0);
        chk("rst_data", {dec_pc, dec_inst, dec_imm}, 0);
        ibuffer_instr_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 13; k++) begin
            ibuffer_instr_valid = 1'b1;
            ibuffer_inst_out    = vec[k].inst;
            ibuffer_pc_out      = 64'h80000000 + 64'(k * 4);
            tick();
            ibuffer_instr_valid = 1'b0;
            chk($sformatf("tbl_valid[%0d]", k), dec_valid, 1);
            chk($sformatf("tbl_pc[%0d]", k), dec_pc, 64'h80000000 + 64'(k * 4));
            chk($sformatf("tbl_fu[%0d]", k), dec_fu_type, vec[k].fu);
            chk($sformatf("tbl_wen[%0d]", k), dec_rd_wen, vec[k].wen);
            chk($sformatf("tbl_imm[%0d]", k), dec_imm, vec[k].imm);
            chk($sformatf("tbl_ill[%0d]", k), dec_illegal, vec[k].ill);
            chk($sformatf("tbl_rd_rs1[%0d]", k), {dec_rd, dec_rs1}, {vec[k].inst[11:7], vec[k].inst[19:15]});
            tick();
            chk($sformatf("tbl_drop[%0d]", k), dec_valid, 0);
        end

        // Back-to-back stream with a 3-cycle stall in the middle.
        perf0   = perf_dispatched;
        idx     = 0;
        cyc     = 0;
        falls   = 0;
        prev_re = 1'b1;
        while (got.size() < 8 && cyc < 40) begin
            ibuffer_instr_valid = (idx < 8);
            ibuffer_inst_out    = 32'h00000093 | (32'(idx) << 20);
            ibuffer_pc_out      = 64'h80000000 + 64'(idx * 4);
            backend_stall       = (cyc >= 3 && cyc < 6);
            @(negedge clock);
            pop = fifo_read_en && ibuffer_instr_valid;
            if (prev_re && !fifo_read_en) falls++;
            prev_re = fifo_read_en;
            if (dec_valid && !backend_stall) got.push_back(dec_pc);
            tick();
            if (pop) idx++;
            cyc++;
        end
        backend_stall       = 1'b0;
        ibuffer_instr_valid = 1'b0;
        chk("stream_count", 64'(got.size()), 8);
        for (int k = 0; k < got.size(); k++)
            chk($sformatf("stream_order[%0d]", k), got[k], 64'h80000000 + 64'(k * 4));
        chk("stream_skid_captures", 64'(falls), 1);
        chk("stream_perf", perf_dispatched - perf0, 8);
        tick();

        // Fill output + skid under stall, then redirect.
        backend_stall       = 1'b1;
        ibuffer_instr_valid = 1'b1;
        ibuffer_inst_out    = 32'h00500093;
        ibuffer_pc_out      = 64'h90000000;
        tick();
        ibuffer_pc_out = 64'h90000004;
        tick();
        chk("redir_skid_full_re", fifo_read_en, 0);
        redirect_valid = 1'b1;
        #1;
        chk("redir_cycle_re", fifo_read_en, 0);
        tick();
        redirect_valid      = 1'b0;
        ibuffer_instr_valid = 1'b0;
        #1;
        chk("redir_after_valid", dec_valid, 0);
        chk("redir_after_re", fifo_read_en, 1);
        backend_stall = 1'b0;
        tick();

        // Asynchronous reset with skid full.
        backend_stall       = 1'b1;
        ibuffer_instr_valid = 1'b1;
        ibuffer_pc_out      = 64'hA0000000;
        tick();
        ibuffer_pc_out = 64'hA0000004;
        tick();
        chk("areset_pre_skid", fifo_read_en, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valid", dec_valid, 0);
        chk("areset_re", fifo_read_en, 0);
        chk("areset_perf", perf_dispatched, 0);
        chk("areset_data", {dec_pc, dec_inst, dec_imm}, 0);
        chk("areset_flags", {dec_rd_wen, dec_illegal, dec_fu_type}, 0);
        backend_stall       = 1'b0;
        ibuffer_instr_valid = 1'b0;
        tick();
        reset_n             = 1'b1;
        ibuffer_instr_valid = 1'b1;
        ibuffer_inst_out    = 32'hFE000EE3;
        ibuffer_pc_out      = 64'hB0000000;
        tick();
        ibuffer_instr_valid = 1'b0;
        chk("post_reset_valid", dec_valid, 1);
        chk("post_reset_pc", dec_pc, 64'hB0000000);
        chk("post_reset_imm", dec_imm, 64'hFFFFFFFFFFFFFFFC);
        tick();

        // Random traffic; the scoreboard checks every cycle.
        for (int c = 0; c < 500; c++) begin
            r                   = $urandom;
            ibuffer_instr_valid = ($urandom_range(0, 3) != 0);
            backend_stall       = ($urandom_range(0, 2) == 0);
            redirect_valid      = ($urandom_range(0, 19) == 0);
            ibuffer_inst_out    = {r[31:7], ops[$urandom_range(0, 15)]};
            ibuffer_pc_out      = 64'hC0000000 + 64'(c * 4);
            tick();
        end
        ibuffer_instr_valid = 1'b0;
        backend_stall       = 1'b0;
        redirect_valid      = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- First backend-facing stage. It consumes the instruction-buffer output of the frontend (valid, 32-bit instruction, PC) and pops the buffer through fifo_read_en.
- It decodes RV64I fields into a registered decode packet for the dispatch logic.
- A one-entry skid buffer keeps fifo_read_en free of any combinational path from backend_stall.
- redirect_valid flushes all in-flight state.

Parameters:
- XLEN, 64, width of the decoded immediate.
- PERF_CNT_W, 64, width of the dispatched-instruction counter.

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset, asynchronous assert, active-low
- redirect_valid  input  1  flush: drop the skid entry and the output register
- ibuffer_instr_valid  input  1  ibuffer head holds an instruction (show-ahead)
- ibuffer_inst_out  input  32  head instruction
- ibuffer_pc_out  input  `PC_RANGE  head PC
- fifo_read_en  output  1  pop ibuffer head; a transfer occurs when this and ibuffer_instr_valid are both 1
- backend_stall  input  1  consumer cannot take the decode packet this cycle
- dec_valid  output  1  decode packet valid
- dec_pc  output  `PC_RANGE  instruction PC
- dec_inst  output  32  raw instruction
- dec_rs1, dec_rs2, dec_rd  output  5 each  register indices
- dec_rd_wen  output  1  writes rd and rd!=0
- dec_imm  output  XLEN  sign-extended immediate
- dec_fu_type  output  3  fu_type_e
- dec_illegal  output  1  unsupported encoding
- perf_dispatched  output  PERF_CNT_W  count of packets consumed downstream

Behaviour:
- Reset (async, reset_n=0): dec_valid=0, skid_valid=0, perf_dispatched=0, all dec_* data fields=0. fifo_read_en is 0 while in reset.
- fifo_read_en = !skid_valid && !redirect_valid. It depends only on registered state and redirect_valid.
- Output advances when out_free = !dec_valid || !backend_stall.
- A ibuffer transfer in cycle N with out_free=1 and skid empty: the packet is written into the output regs; dec_valid=1 in cycle N+1. Latency is 1 cycle.
- Transfer with out_free=0: the raw inst/PC are captured into the skid entry; skid_valid=1.
- skid_valid=1 and out_free=1: the skid entry is decoded into the output regs and skid_valid clears. fifo_read_en rises the following cycle.
- Ordering: skid content always precedes new ibuffer data. No instruction is lost or duplicated. Throughput is 1 instr/cycle when backend_stall=0.
- dec_valid=1 and backend_stall=1: every dec_* output holds stable.
- dec_valid=1, backend_stall=0, nothing to load: dec_valid drops to 0 next cycle.
- redirect_valid=1 (highest priority): next cycle dec_valid=0 and skid_valid=0. Any concurrent ibuffer data is not popped (fifo_read_en=0).
- redirect_valid during stall: the flush still wins.
- perf_dispatched increments by 1 on each cycle with dec_valid && !backend_stall && !redirect_valid. It wraps modulo 2^PERF_CNT_W.
- Decode is combinational on the selected source (skid or ibuffer) and registered into dec_*.
- fu_type by opcode[6:0]:
  - OP/OP-IMM/OP-32/OP-IMM-32/LUI/AUIPC -> ALU(0)
  - BRANCH/JAL/JALR -> BRU(1)
  - LOAD -> LDU(2)
  - STORE -> STU(3)
  - SYSTEM/MISC-MEM -> CSR(4)
- Immediates:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - All sign-extended from inst[31] to XLEN. R-type imm=0.
- dec_rd_wen=0 for BRANCH/STORE/MISC-MEM or when rd==0.
- dec_illegal=1 when inst[1:0]!=2'b11 or the opcode is not listed. In that case fu_type=ALU, rd_wen=0, imm=0.

Decomposition:
- decode_pkg holds:
  - opcode localparams
  - fu_type_e (3-bit enum)
  - imm_type_e (I/S/B/U/J/NONE)
  - dec_pkt_t struct with pc, inst, rs1, rs2, rd, rd_wen, imm, fu_type, illegal
- Sub-module rv64_decoder: purely combinational, inst -> dec_pkt_t fields. decode_stage instantiates it once on the skid/ibuffer mux output.

Test Plan:
- addi x1,x0,5 (0x00500093) at PC 0x80000000, no stall -> next cycle dec_valid=1, rd=1, rs1=0, imm=5, fu=ALU, rd_wen=1, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFFFFFFFFFC, fu=BRU, rd_wen=0.
- Back-to-back stream of 0x80000000..0x8000001C; backend_stall=1 for 3 cycles mid-stream:
  - exactly one skid capture; fifo_read_en=0 while skid full.
  - packets exit in PC order with no gaps or duplicates.
  - perf_dispatched=8.
- Stall with skid full, then redirect_valid=1 for 1 cycle -> next cycle dec_valid=0 and skid empty. fifo_read_en=0 during the redirect cycle and 1 the cycle after.
- Instruction 0x00000000 -> dec_illegal=1, fu=ALU, rd_wen=0, imm=0.
- reset_n deasserted asynchronously mid-stream with skid full -> all outputs 0 immediately. After release, the first transfer appears with 1-cycle latency.
